light_timer_fsm: RTL and testbench

LIGHT_TIMER_FSM -- requirements
Module: light_timer_fsm

---
 rtl/light_timer_fsm.sv | 186 ++++++++++++++++++
 tb/tb_light_timer_fsm.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_timer_fsm.sv
// light_timer_fsm: sensor-triggered lamp timer.
// A trigger (sticky 'passed' seen high outside REARM) re-arms the upstream
// sensor through a short REARM pulse on sens_reset, keeps the lamp on, then
// blinks it during a closing WARN phase before returning to IDLE.
// Optional feature: define MANUAL_OVERRIDE_EN to add the force_on input,
// which holds the lamp in ON with the timer reloaded every cycle.
module light_timer_fsm #(
  parameter int ON_CYCLES    = 1000,
  parameter int WARN_CYCLES  = 100,
  parameter int BLINK_CYCLES = 10,
  parameter int REARM_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       passed,
`ifdef MANUAL_OVERRIDE_EN
  input  logic       force_on,
`endif
  output logic       sens_reset,
  output logic       light_on,
  output logic       warn,
  output logic [7:0] event_cnt,
  output logic       busy
);

  localparam int TW = $clog2(ON_CYCLES + 1);
  localparam int RW = $clog2(REARM_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  localparam logic [TW-1:0] LP_TMR_LOAD   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] LP_TMR_WARN   = TW'(WARN_CYCLES);
  localparam logic [TW-1:0] LP_TMR_ONE    = TW'(1);
  localparam logic [RW-1:0] LP_REARM_LOAD = RW'(REARM_CYCLES - 1);
  localparam logic [RW-1:0] LP_REARM_ONE  = RW'(1);
  localparam logic [BW-1:0] LP_BLINK_LOAD = BW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0] LP_BLINK_ONE  = BW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REARM = 2'd1,
    S_ON    = 2'd2,
    S_WARN  = 2'd3
  } state_t;

  // State and counters
  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [RW-1:0]   r_rearm_cnt;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blink_ph;

  // Registered outputs
  logic            r_sens_reset;
  logic            r_light_on;
  logic            r_warn;
  logic            r_busy;
  logic [7:0]      r_event_cnt;

  // Next-state values
  state_t          w_state_nxt;
  logic [TW-1:0]   w_timer_nxt;
  logic [RW-1:0]   w_rearm_nxt;
  logic [BW-1:0]   w_blink_cnt_nxt;
  logic            w_blink_ph_nxt;
  logic [7:0]      w_event_cnt_nxt;
  logic            w_sens_reset_nxt;
  logic            w_light_on_nxt;
  logic            w_warn_nxt;
  logic            w_busy_nxt;

  logic            w_trigger;
  logic            w_force;

`ifdef MANUAL_OVERRIDE_EN
  assign w_force = force_on;
`else
  assign w_force = 1'b0;
`endif

  // passed is ignored while the upstream stage is still being cleared
  assign w_trigger = passed && (r_state != S_REARM);

  // Next-state, counter and output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_rearm_nxt     = r_rearm_cnt;
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_ph_nxt  = r_blink_ph;
    w_event_cnt_nxt = r_event_cnt;

    case (r_state)
      S_IDLE: begin
        w_timer_nxt = r_timer;
      end
      S_REARM: begin
        w_timer_nxt = r_timer - LP_TMR_ONE;
        if (r_rearm_cnt == '0) begin
          w_state_nxt = S_ON;
        end else begin
          w_rearm_nxt = r_rearm_cnt - LP_REARM_ONE;
        end
      end
      S_ON: begin
        w_timer_nxt = r_timer - LP_TMR_ONE;
        if (r_timer == LP_TMR_WARN) begin
          // Blink starts in the dark half of its period
          w_state_nxt     = S_WARN;
          w_blink_cnt_nxt = LP_BLINK_LOAD;
          w_blink_ph_nxt  = 1'b0;
        end
      end
      S_WARN: begin
        if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - LP_TMR_ONE;
          if (r_blink_cnt == '0) begin
            w_blink_cnt_nxt = LP_BLINK_LOAD;
            w_blink_ph_nxt  = ~r_blink_ph;
          end else begin
            w_blink_cnt_nxt = r_blink_cnt - LP_BLINK_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A trigger outranks expiry and override; the override never cuts a
    // REARM pulse short so the upstream stage is always fully cleared
    if (w_trigger) begin
      w_state_nxt = S_REARM;
      w_timer_nxt = LP_TMR_LOAD;
      w_rearm_nxt = LP_REARM_LOAD;
      if (r_event_cnt != 8'hFF) begin
        w_event_cnt_nxt = r_event_cnt + 8'd1;
      end
    end else if (w_force && (r_state != S_REARM)) begin
      w_state_nxt = S_ON;
      w_timer_nxt = LP_TMR_LOAD;
    end

    // Outputs decoded from the next state so they can be registered
    w_sens_reset_nxt = (w_state_nxt == S_REARM);
    w_warn_nxt       = (w_state_nxt == S_WARN);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_light_on_nxt   = (w_state_nxt == S_REARM) || (w_state_nxt == S_ON) ||
                       ((w_state_nxt == S_WARN) && w_blink_ph_nxt);
  end

  // State and output registers; reset holds the upstream sensor cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_rearm_cnt  <= '0;
      r_blink_cnt  <= '0;
      r_blink_ph   <= 1'b0;
      r_event_cnt  <= 8'd0;
      r_sens_reset <= 1'b1;
      r_light_on   <= 1'b0;
      r_warn       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_rearm_cnt  <= w_rearm_nxt;
      r_blink_cnt  <= w_blink_cnt_nxt;
      r_blink_ph   <= w_blink_ph_nxt;
      r_event_cnt  <= w_event_cnt_nxt;
      r_sens_reset <= w_sens_reset_nxt;
      r_light_on   <= w_light_on_nxt;
      r_warn       <= w_warn_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign sens_reset = r_sens_reset;
  assign light_on   = r_light_on;
  assign warn       = r_warn;
  assign busy       = r_busy;
  assign event_cnt  = r_event_cnt;

endmodule

// File: tb/tb_light_timer_fsm.sv
// Testbench for light_timer_fsm. The reference model tracks only the number
// of cycles elapsed since the last accepted trigger and derives every output
// from that age. Override scenario is built when MANUAL_OVERRIDE_EN is defined.
module tb_light_timer_fsm;

  localparam int P_ON    = 20;
  localparam int P_WARN  = 6;
  localparam int P_BLINK = 2;
  localparam int P_REARM = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       passed = 1'b0;
`ifdef MANUAL_OVERRIDE_EN
  logic       force_on = 1'b0;
`endif
  logic       sens_reset;
  logic       light_on;
  logic       warn;
  logic [7:0] event_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_age;    // 0 = idle, else cycles since accepted trigger (1-based)
  int m_cnt;
  bit m_skip;   // sequence entered via override: no REARM part
  bit m_sinit;  // sens_reset still high from reset

  wire [11:0] obs = {sens_reset, light_on, warn, busy, event_cnt};

  light_timer_fsm #(
    .ON_CYCLES(P_ON), .WARN_CYCLES(P_WARN),
    .BLINK_CYCLES(P_BLINK), .REARM_CYCLES(P_REARM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .passed(passed),
`ifdef MANUAL_OVERRIDE_EN
    .force_on(force_on),
`endif
    .sens_reset(sens_reset),
    .light_on(light_on),
    .warn(warn),
    .event_cnt(event_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_vec();
    logic s, l, w, b;
    s = 1'b0; l = 1'b0; w = 1'b0; b = 1'b0;
    if (m_age == 0) begin
      s = m_sinit;
    end else begin
      b = 1'b1;
      if (m_age <= P_REARM && !m_skip) s = 1'b1;
      if (m_age <= P_ON - P_WARN) l = 1'b1;
      else begin
        w = 1'b1;
        l = (((m_age - (P_ON - P_WARN) - 1) / P_BLINK) % 2) == 1;
      end
    end
    return {s, l, w, b, 8'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_age = 0; m_cnt = 0; m_skip = 1'b0; m_sinit = 1'b1;
  endtask

  task automatic model_step(input logic p, input logic f);
    bit in_rearm;
    if (!reset) begin
      model_reset();
      return;
    end
    m_sinit = 1'b0;
    in_rearm = (m_age != 0) && (m_age <= P_REARM) && !m_skip;
    if (p && !in_rearm) begin
      m_age = 1; m_skip = 1'b0;
      if (m_cnt < 255) m_cnt++;
    end else if (f && !in_rearm) begin
      m_age = 1; m_skip = 1'b1;
    end else if (m_age != 0) begin
      m_age++;
      if (m_age > P_ON) m_age = 0;
    end
  endtask

  // One clock: model follows the DUT edge, upstream drops passed one cycle
  // after it saw sens_reset high
  task automatic tick();
    logic sr_prev, p, f;
    sr_prev = sens_reset;
    p = passed;
`ifdef MANUAL_OVERRIDE_EN
    f = force_on;
`else
    f = 1'b0;
`endif
    @(posedge clk);
    model_step(p, f);
    #1;
    if (sr_prev) passed = 1'b0;
  endtask

  task automatic do_reset();
    passed = 1'b0;
`ifdef MANUAL_OVERRIDE_EN
    force_on = 1'b0;
`endif
    reset = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    passed = 1'b0;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 12'b1000_0000_0000) begin
        errors++;
        $display("FAIL reset_hold got=%h exp=%h", obs, 12'h800);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release_pre_edge got=%h exp=%h", obs, exp_vec());
    end
    tick();
    checks++;
    if (sens_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_sens_drop got=%b exp=0", sens_reset);
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_after_edge got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_single();
    int n_on, n_warn, n_sens;
    logic [5:0] pat;
    n_on = 0; n_warn = 0; n_sens = 0; pat = '0;
    do_reset();
    passed = 1'b1;
    for (int i = 0; i < 26; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (light_on !== 1'b1 || sens_reset !== 1'b1) begin
          errors++;
          $display("FAIL single_latency got=%b%b exp=11", light_on, sens_reset);
        end
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL single_seq cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      if (busy && light_on && !warn) n_on++;
      if (warn) begin pat = {pat[4:0], light_on}; n_warn++; end
      if (sens_reset) n_sens++;
    end
    checks++;
    if (n_on !== 14) begin
      errors++;
      $display("FAIL single_on_len got=%0d exp=14", n_on);
    end
    checks++;
    if (n_warn !== 6 || pat !== 6'b001100) begin
      errors++;
      $display("FAIL single_warn got=%0d/%b exp=6/001100", n_warn, pat);
    end
    checks++;
    if (n_sens !== 2) begin
      errors++;
      $display("FAIL single_rearm_len got=%0d exp=2", n_sens);
    end
    checks++;
    if (busy !== 1'b0 || event_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single_end got=%b/%0d exp=0/1", busy, event_cnt);
    end
  endtask

  task automatic test_retrigger();
    int n_warn, n_on, guard;
    n_warn = 0; n_on = 0; guard = 0;
    do_reset();
    passed = 1'b1;
    while (n_warn < 3 && guard < 40) begin
      tick();
      guard++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL retrig_pre got=%h exp=%h", obs, exp_vec());
      end
      if (warn) n_warn++;
    end
    checks++;
    if (n_warn != 3) begin
      errors++;
      $display("FAIL retrig_timeout got=%0d exp=3", n_warn);
    end
    passed = 1'b1;
    n_warn = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (warn !== 1'b0 || sens_reset !== 1'b1 || light_on !== 1'b1) begin
          errors++;
          $display("FAIL retrig_rearm got=%b%b%b exp=011", warn, sens_reset, light_on);
        end
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL retrig_seq cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      if (busy && light_on && !warn) n_on++;
      if (warn) n_warn++;
    end
    checks++;
    if (n_on !== 14 || n_warn !== 6 || busy !== 1'b0 || event_cnt !== 8'd2) begin
      errors++;
      $display("FAIL retrig_end got=%0d/%0d/%b/%0d exp=14/6/0/2", n_on, n_warn, busy, event_cnt);
    end
  endtask

  task automatic test_rearm_ignore();
    do_reset();
    passed = 1'b1;
    tick();
    for (int i = 0; i < P_REARM; i++) begin
      passed = 1'b1;
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL rearm_ign_seq got=%h exp=%h", obs, exp_vec());
      end
    end
    checks++;
    if (event_cnt !== 8'd1 || sens_reset !== 1'b0 || light_on !== 1'b1) begin
      errors++;
      $display("FAIL rearm_ign_cnt got=%0d/%b/%b exp=1/0/1", event_cnt, sens_reset, light_on);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL rearm_ign_tail cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_expiry_trigger();
    int guard;
    guard = 0;
    do_reset();
    passed = 1'b1;
    tick();
    while (m_age != P_ON && guard < 40) begin
      tick();
      guard++;
    end
    checks++;
    if (obs !== exp_vec() || m_age != P_ON) begin
      errors++;
      $display("FAIL expiry_last_warn got=%h exp=%h age=%0d", obs, exp_vec(), m_age);
    end
    passed = 1'b1;
    tick();
    checks++;
    if (sens_reset !== 1'b1 || light_on !== 1'b1 || warn !== 1'b0 || event_cnt !== 8'd2) begin
      errors++;
      $display("FAIL expiry_trigger_wins got=%b%b%b/%0d exp=110/2", sens_reset, light_on, warn, event_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      passed = 1'b1;
      for (int j = 0; j <= P_REARM; j++) begin
        tick();
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL sat_seq k=%0d got=%h exp=%h", k, obs, exp_vec());
        end
      end
    end
    checks++;
    if (event_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_hold got=%0d exp=255", event_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!passed && $urandom_range(0, 9) == 0) passed = 1'b1;
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    passed = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (light_on !== 1'b1 || sens_reset !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_on got=%h", obs);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 12'b1000_0000_0000) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", obs, 12'h800);
    end
    model_reset();
    tick();
    reset = 1'b1;
  endtask

`ifdef MANUAL_OVERRIDE_EN
  task automatic test_override();
    int n_on, n_warn;
    n_on = 0; n_warn = 0;
    do_reset();
    force_on = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 25) passed = 1'b1;
      tick();
      checks++;
      if (light_on !== 1'b1 || warn !== 1'b0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL override_hold cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (event_cnt !== 8'd1) begin
      errors++;
      $display("FAIL override_count got=%0d exp=1", event_cnt);
    end
    force_on = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (busy && light_on && !warn) n_on++;
      if (warn) n_warn++;
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL override_release cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (n_on !== 14 || n_warn !== 6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL override_tail got=%0d/%0d/%b exp=14/6/0", n_on, n_warn, busy);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_retrigger();
    test_rearm_ignore();
    test_expiry_trigger();
    test_saturate();
    test_random();
    test_async_reset();
`ifdef MANUAL_OVERRIDE_EN
    test_override();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
